// File: rtl/motor_pkg.sv
// Shared constants, state encoding and command payload for the motor command scheduler.
package motor_pkg;

    localparam int unsigned N_MOTOR = 6;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LVL_W   = 3;
    localparam int unsigned BCD_W   = 12;
    localparam int unsigned BUSY_TO = 16;
    localparam int unsigned TMR_W   = 4;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        IDLE      = 3'd1,
        CALC      = 3'd2,
        ISSUE     = 3'd3,
        WAIT_HI   = 3'd4,
        WAIT_LO   = 3'd5
    } state_t;

    // FIFO entry: motor index plus binary target position.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [POS_W-1:0] tgt;
    } cmd_t;

    // Three BCD digits (hundreds, tens, ones) to binary.
    function automatic logic [POS_W-1:0] bcd_to_bin(input logic [BCD_W-1:0] b);
        return POS_W'(b[11:8]) * POS_W'(100) + POS_W'(b[7:4]) * POS_W'(10) + POS_W'(b[3:0]);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO with registered full/empty/level flags.
// Ports: clk, rst_n, push/pop strobes, wdata in, head_c (current head, combinational),
//        full, empty, level (occupancy 0..DEPTH).
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [PTR_W:0]   level_n;

    // Guarded strobes and next occupancy.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        level_n = level;
        if (do_push && !do_pop) begin
            level_n = level + (PTR_W+1)'(1);
        end else if (!do_push && do_pop) begin
            level_n = level - (PTR_W+1)'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_n;
            full  <= (level_n == (PTR_W+1)'(DEPTH));
            empty <= (level_n == '0);
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head_c = mem[rd_ptr];

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Queued absolute-position move scheduler for the shared stepper pulse generator.
// Ports: sysclk, rst_n; cmd_valid/cmd_ready/cmd_motor/cmd_bcd command input, cmd_err reject pulse;
//        init_done and Busy from the pulse generator; MotorOut/PulseNum/DROut/go move issue;
//        q_level FIFO occupancy.
module motor_cmd_scheduler
    import motor_pkg::*;
(
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [N_MOTOR-1:0] cmd_motor,
    input  logic [BCD_W-1:0]   cmd_bcd,
    output logic               cmd_err,
    input  logic               init_done,
    input  logic               Busy,
    output logic [N_MOTOR-1:0] MotorOut,
    output logic [POS_W-1:0]   PulseNum,
    output logic [N_MOTOR-1:0] DROut,
    output logic               go,
    output logic [LVL_W-1:0]   q_level
);

    state_t              state, state_n;
    cmd_t                cur;
    cmd_t                fifo_head;
    cmd_t                wentry_c;
    logic                fifo_full, fifo_empty;
    logic [POS_W-1:0]    pos [N_MOTOR];
    logic                init_d;
    logic [TMR_W-1:0]    tmr, tmr_n;

    logic [IDX_W-1:0]    cmd_idx_c;
    logic                onehot_c, digits_ok_c, cmd_ok_c, push_c;
    logic signed [POS_W:0] diff_c;

    logic                pop_c, ld_cur_c, pos_we_c, go_n;
    logic [N_MOTOR-1:0]  motor_n, dr_n;
    logic [POS_W-1:0]    pulse_n;

    // Input validation and BCD decode.
    always_comb begin
        cmd_idx_c = '0;
        for (int i = 0; i < N_MOTOR; i++) begin
            if (cmd_motor[i]) cmd_idx_c = IDX_W'(i);
        end
        onehot_c    = (cmd_motor != '0) && ((cmd_motor & (cmd_motor - N_MOTOR'(1))) == '0);
        digits_ok_c = (cmd_bcd[11:8] <= BCD_MAX) && (cmd_bcd[7:4] <= BCD_MAX)
                   && (cmd_bcd[3:0] <= BCD_MAX);
        cmd_ok_c    = onehot_c && digits_ok_c;
        push_c      = cmd_valid && cmd_ok_c && !fifo_full;
        wentry_c    = '{idx: cmd_idx_c, tgt: bcd_to_bin(cmd_bcd)};
    end

    assign cmd_ready = !fifo_full;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(cmd_t))
    ) u_fifo (
        .clk    (sysclk),
        .rst_n  (rst_n),
        .push   (push_c),
        .pop    (pop_c),
        .wdata  (wentry_c),
        .head_c (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (q_level)
    );

    // Signed distance from the motor's current position to the popped target.
    assign diff_c = $signed({1'b0, cur.tgt}) - $signed({1'b0, pos[cur.idx]});

    // State register.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_INIT;
        else        state <= state_n;
    end

    // Next state and next values of the registered move outputs.
    always_comb begin
        state_n  = state;
        pop_c    = 1'b0;
        ld_cur_c = 1'b0;
        pos_we_c = 1'b0;
        tmr_n    = tmr;
        go_n     = 1'b0;
        motor_n  = MotorOut;
        pulse_n  = PulseNum;
        dr_n     = DROut;
        case (state)
            WAIT_INIT: begin
                if (init_done) state_n = IDLE;
            end
            IDLE: begin
                // Losing homing takes priority over starting a new move.
                if (!init_done) begin
                    state_n = WAIT_INIT;
                end else if (!fifo_empty) begin
                    pop_c    = 1'b1;
                    ld_cur_c = 1'b1;
                    state_n  = CALC;
                end
            end
            CALC: begin
                if (diff_c == '0) begin
                    state_n = IDLE;
                end else begin
                    motor_n = N_MOTOR'(1) << cur.idx;
                    pulse_n = diff_c[POS_W] ? POS_W'(-diff_c) : POS_W'(diff_c);
                    dr_n    = diff_c[POS_W] ? '0 : (N_MOTOR'(1) << cur.idx);
                    go_n    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                tmr_n   = '0;
                state_n = WAIT_HI;
            end
            WAIT_HI: begin
                if (Busy) begin
                    state_n = WAIT_LO;
                end else if (tmr == TMR_W'(BUSY_TO - 1)) begin
                    // Generator never acknowledged: drop the move, keep pos unchanged.
                    motor_n = '0;
                    pulse_n = '0;
                    dr_n    = '0;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr + TMR_W'(1);
                end
            end
            WAIT_LO: begin
                if (!Busy) begin
                    pos_we_c = 1'b1;
                    motor_n  = '0;
                    pulse_n  = '0;
                    dr_n     = '0;
                    state_n  = IDLE;
                end
            end
            default: state_n = WAIT_INIT;
        endcase
    end

    // Datapath registers: outputs, current command, position table.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            tmr      <= '0;
            cur      <= '0;
            MotorOut <= '0;
            PulseNum <= '0;
            DROut    <= '0;
            go       <= 1'b0;
            cmd_err  <= 1'b0;
            init_d   <= 1'b0;
            for (int i = 0; i < N_MOTOR; i++) pos[i] <= '0;
        end else begin
            tmr      <= tmr_n;
            MotorOut <= motor_n;
            PulseNum <= pulse_n;
            DROut    <= dr_n;
            go       <= go_n;
            cmd_err  <= cmd_valid && !cmd_ok_c;
            init_d   <= init_done;
            if (ld_cur_c) cur <= fifo_head;
            // A fresh homing pass re-zeroes every motor.
            if (init_done && !init_d) begin
                for (int i = 0; i < N_MOTOR; i++) pos[i] <= '0;
            end else if (pos_we_c) begin
                pos[cur.idx] <= cur.tgt;
            end
        end
    end

endmodule
